// File: rtl/env_pkg.sv
// Shared types for the environment frame sequencer: FSM states and the buffered
// point record.
package env_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      DRAIN     = 2'd3
   } seq_state_t;

   localparam int POINT_COORD_BITS = 32;

   typedef struct packed {
      logic [POINT_COORD_BITS-1:0] x;
      logic [POINT_COORD_BITS-1:0] y;
   } point_t;

endpackage

// File: rtl/point_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry whenever empty is low.
// A push into a full FIFO is taken only when a pop frees a slot the same cycle.
module point_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == FULL_COUNT);
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr_reg];

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/env_frame_sequencer.sv
// Per-frame scheduler: starts the environment manager on each tick, buffers its
// unthrottled point stream, and reports completion, overrun, overflow, timeout.
module env_frame_sequencer
   import env_pkg::*;
#(
   parameter int WORLD_BITS     = 32,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int FRAME_BITS     = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  frame_tick_in,
   input  logic                  pause_in,
   output logic                  env_start_out,
   input  logic                  env_valid_in,
   input  logic [WORLD_BITS-1:0] env_x_in,
   input  logic [WORLD_BITS-1:0] env_y_in,
   input  logic                  env_done_in,
   output logic                  pt_valid_out,
   input  logic                  pt_ready_in,
   output logic [WORLD_BITS-1:0] pt_x_out,
   output logic [WORLD_BITS-1:0] pt_y_out,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  overrun_out,
   output logic                  overflow_out,
   output logic                  timeout_out,
   output logic [FRAME_BITS-1:0] frame_count_out
);
   localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

   seq_state_t              state_reg;
   seq_state_t              state_next;
   logic [WD_BITS-1:0]      wd_reg;
   logic                    overflow_reg;
   logic                    timeout_reg;
   logic [FRAME_BITS-1:0]   frame_count_reg;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push_req;
   logic                    pop;
   logic                    drop;
   logic                    timeout_hit;
   logic [2*WORLD_BITS-1:0] fifo_dout;

   assign push_req    = env_valid_in && ((state_reg == WAIT_DONE) || (state_reg == DRAIN));
   assign pop         = !fifo_empty && pt_ready_in;
   assign drop        = push_req && fifo_full && !pop;
   assign timeout_hit = (wd_reg == WD_LAST);

   point_fifo #(
      .WIDTH(2*WORLD_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_point_fifo (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .push  (push_req),
      .pop   (pop),
      .din   ({env_x_in, env_y_in}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_next     = state_reg;
      env_start_out  = 1'b0;
      frame_done_out = 1'b0;
      case (state_reg)
         IDLE: begin
            if (frame_tick_in && !pause_in) state_next = START;
         end
         START: begin
            env_start_out = 1'b1;
            state_next    = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Done takes priority over a watchdog expiry in the same cycle.
            if (env_done_in || timeout_hit) state_next = DRAIN;
         end
         DRAIN: begin
            if (fifo_empty && !push_req) begin
               frame_done_out = 1'b1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg       <= IDLE;
         wd_reg          <= '0;
         overflow_reg    <= 1'b0;
         timeout_reg     <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         wd_reg    <= (state_reg == WAIT_DONE) ? wd_reg + 1'b1 : '0;
         if (state_reg == START) begin
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
         end else begin
            if (drop) overflow_reg <= 1'b1;
            if ((state_reg == WAIT_DONE) && !env_done_in && timeout_hit) timeout_reg <= 1'b1;
         end
         if (frame_done_out) frame_count_reg <= frame_count_reg + 1'b1;
      end
   end

   assign busy_out        = (state_reg != IDLE);
   assign overrun_out     = frame_tick_in && busy_out;
   assign overflow_out    = overflow_reg;
   assign timeout_out     = timeout_reg;
   assign frame_count_out = frame_count_reg;
   assign pt_valid_out    = !fifo_empty;
   assign pt_x_out        = pt_valid_out ? fifo_dout[2*WORLD_BITS-1:WORLD_BITS] : '0;
   assign pt_y_out        = pt_valid_out ? fifo_dout[WORLD_BITS-1:0] : '0;

endmodule

// File: tb/tb_env_frame_sequencer.sv
// Directed bench for env_frame_sequencer: normal frame, backpressure overflow,
// full push/pop, timeout, overrun, pause and mid-drain reset.
module tb_env_frame_sequencer;
   localparam int WB = 32;
   localparam int FB = 16;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          frame_tick_in = 1'b0;
   logic          pause_in = 1'b0;
   logic          env_valid_in = 1'b0;
   logic [WB-1:0] env_x_in = '0;
   logic [WB-1:0] env_y_in = '0;
   logic          env_done_in = 1'b0;
   logic          pt_ready_in = 1'b0;
   logic          env_start_out;
   logic          pt_valid_out;
   logic [WB-1:0] pt_x_out;
   logic [WB-1:0] pt_y_out;
   logic          busy_out;
   logic          frame_done_out;
   logic          overrun_out;
   logic          overflow_out;
   logic          timeout_out;
   logic [FB-1:0] frame_count_out;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   int overrun_cnt = 0;
   int s0;
   logic [63:0] popq[$];

   always #5 clk_in = ~clk_in;

   env_frame_sequencer #(
      .WORLD_BITS(WB),
      .FIFO_DEPTH(16),
      .TIMEOUT_CYCLES(64),
      .FRAME_BITS(FB)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .frame_tick_in(frame_tick_in),
      .pause_in(pause_in),
      .env_start_out(env_start_out),
      .env_valid_in(env_valid_in),
      .env_x_in(env_x_in),
      .env_y_in(env_y_in),
      .env_done_in(env_done_in),
      .pt_valid_out(pt_valid_out),
      .pt_ready_in(pt_ready_in),
      .pt_x_out(pt_x_out),
      .pt_y_out(pt_y_out),
      .busy_out(busy_out),
      .frame_done_out(frame_done_out),
      .overrun_out(overrun_out),
      .overflow_out(overflow_out),
      .timeout_out(timeout_out),
      .frame_count_out(frame_count_out)
   );

   // Record pops and pulses mid-cycle, when inputs and outputs are settled.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (pt_valid_out && pt_ready_in) popq.push_back({pt_x_out, pt_y_out});
         if (frame_done_out) done_cnt++;
         if (env_start_out) start_cnt++;
         if (overrun_out) overrun_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_pt(input int v);
      env_valid_in = 1'b1;
      env_x_in     = WB'(v);
      env_y_in     = WB'(2 * v);
      cyc();
      env_valid_in = 1'b0;
   endtask

   task automatic start_frame();
      frame_tick_in = 1'b1;
      cyc();
      frame_tick_in = 1'b0;
      #1;
      chk("start_pulse", env_start_out, 1);
      cyc();
      chk("start_single", env_start_out, 0);
      chk("start_clr_overflow", overflow_out, 0);
      chk("start_clr_timeout", timeout_out, 0);
   endtask

   task automatic wait_frames(input int n);
      int budget = 200;
      while (done_cnt < n && budget > 0) begin
         cyc();
         budget--;
      end
      chk("frame_done_seen", done_cnt, n);
   endtask

   task automatic check_pops(input string tag, input int first, input int n);
      chk({tag, "_count"}, popq.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < popq.size()) chk(tag, popq[i], {WB'(first + i), WB'(2 * (first + i))});
      end
   endtask

   initial begin
      repeat (2) cyc();
      chk("rst_busy", busy_out, 0);
      chk("rst_valid", pt_valid_out, 0);
      chk("rst_start", env_start_out, 0);
      chk("rst_count", frame_count_out, 0);
      chk("rst_overflow", overflow_out, 0);
      rst_in = 1'b0;
      cyc();

      // Normal frame: five points streamed straight through
      pt_ready_in = 1'b1;
      popq.delete();
      start_frame();
      for (int i = 1; i <= 5; i++) push_pt(i);
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      wait_frames(1);
      check_pops("normal_pt", 1, 5);
      chk("normal_count", frame_count_out, 1);
      repeat (3) cyc();
      chk("normal_done_once", done_cnt, 1);
      chk("normal_idle", busy_out, 0);

      // Backpressure: 20 pushes into 16 entries
      pt_ready_in = 1'b0;
      popq.delete();
      start_frame();
      for (int i = 1; i <= 20; i++) push_pt(i);
      chk("bp_overflow", overflow_out, 1);
      chk("bp_valid", pt_valid_out, 1);
      chk("bp_head_x", pt_x_out, 1);
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      repeat (3) cyc();
      chk("bp_stall_hold_x", pt_x_out, 1);
      chk("bp_stall_hold_y", pt_y_out, 2);
      chk("bp_busy", busy_out, 1);
      chk("bp_no_done_yet", done_cnt, 1);
      pt_ready_in = 1'b1;
      wait_frames(2);
      check_pops("bp_pt", 1, 16);
      chk("bp_overflow_sticky", overflow_out, 1);
      chk("bp_count", frame_count_out, 2);

      // Full FIFO with a push and pop in the same cycle
      pt_ready_in = 1'b0;
      popq.delete();
      start_frame();
      for (int i = 1; i <= 16; i++) push_pt(i);
      chk("full_no_overflow", overflow_out, 0);
      env_valid_in = 1'b1;
      env_x_in     = WB'(17);
      env_y_in     = WB'(34);
      pt_ready_in  = 1'b1;
      cyc();
      env_valid_in = 1'b0;
      pt_ready_in  = 1'b0;
      chk("simul_overflow", overflow_out, 0);
      chk("simul_one_pop", popq.size(), 1);
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      pt_ready_in = 1'b1;
      wait_frames(3);
      check_pops("simul_pt", 1, 17);
      chk("simul_overflow_end", overflow_out, 0);

      // Watchdog expiry after 64 WAIT_DONE cycles
      pt_ready_in = 1'b0;
      popq.delete();
      start_frame();
      push_pt(1);
      push_pt(2);
      repeat (61) cyc();
      chk("to_not_yet", timeout_out, 0);
      chk("to_busy", busy_out, 1);
      cyc();
      chk("to_fired", timeout_out, 1);
      chk("to_valid", pt_valid_out, 1);
      pt_ready_in = 1'b1;
      wait_frames(4);
      check_pops("to_pt", 1, 2);
      chk("to_sticky", timeout_out, 1);
      chk("to_count", frame_count_out, 4);

      // Done on the final watchdog cycle wins
      start_frame();
      repeat (63) cyc();
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      chk("edge_timeout", timeout_out, 0);
      chk("edge_busy", busy_out, 1);
      wait_frames(5);
      chk("edge_timeout_end", timeout_out, 0);

      // Tick while busy is reported and dropped
      s0 = start_cnt;
      start_frame();
      frame_tick_in = 1'b1;
      #1;
      chk("overrun_pulse", overrun_out, 1);
      cyc();
      frame_tick_in = 1'b0;
      #1;
      chk("overrun_clear", overrun_out, 0);
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      wait_frames(6);
      chk("overrun_single_start", start_cnt - s0, 1);
      chk("overrun_count", overrun_cnt, 1);

      // Tick while paused does nothing
      s0 = start_cnt;
      pause_in = 1'b1;
      frame_tick_in = 1'b1;
      #1;
      chk("pause_no_overrun", overrun_out, 0);
      cyc();
      frame_tick_in = 1'b0;
      #1;
      chk("pause_no_start", env_start_out, 0);
      chk("pause_idle", busy_out, 0);
      pause_in = 1'b0;
      cyc();
      chk("pause_idle2", busy_out, 0);
      chk("pause_start_cnt", start_cnt, s0);

      // Asynchronous reset mid-DRAIN with three points held
      pt_ready_in = 1'b0;
      start_frame();
      for (int i = 1; i <= 3; i++) push_pt(i);
      env_done_in = 1'b1;
      cyc();
      env_done_in = 1'b0;
      chk("rd_busy", busy_out, 1);
      chk("rd_valid", pt_valid_out, 1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("ar_busy", busy_out, 0);
      chk("ar_valid", pt_valid_out, 0);
      chk("ar_x", pt_x_out, 0);
      chk("ar_y", pt_y_out, 0);
      chk("ar_start", env_start_out, 0);
      chk("ar_done", frame_done_out, 0);
      chk("ar_overrun", overrun_out, 0);
      chk("ar_overflow", overflow_out, 0);
      chk("ar_timeout", timeout_out, 0);
      chk("ar_count", frame_count_out, 0);
      cyc();
      rst_in = 1'b0;
      pt_ready_in = 1'b1;
      cyc();
      chk("post_rst_empty", pt_valid_out, 0);
      chk("post_rst_count", frame_count_out, 0);
      chk("post_rst_idle", busy_out, 0);
      chk("post_rst_no_done", done_cnt, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "bench time limit reached");
   end

endmodule
